align_shift_pipe: RTL
=====================

# align_shift_pipe

Pipelined, parametrised mantissa alignment shifter for the FP add/sub datapath. It is the clocked successor to the combinational 24-bit right shifter. It adds left shift for normalisation and arithmetic right shift. In right-shift modes it produces guard/round/sticky bits for IEEE-754 rounding. A valid/ready handshake with backpressure sits on both sides. It sits between exponent compare (which supplies the shift amount) and the mantissa adder, or between the adder and the rounder when used for normalisation.

## Interface
Parameters:
- WIDTH, 24, mantissa width including hidden bit (24 single, 53 double).
- REG_EVERY, 1, number of shift stages between pipeline registers (1..SHW).
- Derived, not overridable: SHW = $clog2(WIDTH+3) is the shift-amount width. NSEG = ceil(SHW/REG_EVERY) is the pipeline depth.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  WIDTH  mantissa.
- in_sign  in  1  sign bit, passed through unshifted.
- in_shamt  in  SHW  shift amount.
- in_mode  in  2  shift mode: 00 logical right, 01 arithmetic right, 10 left, 11 reserved (treated as 00).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  shifted mantissa.
- out_sign  out  1  in_sign delayed to match out_data.
- out_grs  out  3  {guard, round, sticky}; 000 in left mode.
- out_ovf  out  1  left mode only: a 1 bit was shifted out of the MSB.

## Operation
- Internal working vector: ext = {in_data, 3'b000}, width WIDTH+3. The shift is log2-decomposed: stage k shifts by 2^k when in_shamt[k] = 1, for k = 0..SHW-1.
- Right modes:
  - Bits leaving ext[0] are ORed into a running sticky bit.
  - Fill bits are 0 for logical right and ext MSB for arithmetic right.
  - Result: out_data = ext[WIDTH+2:3]; out_grs = {ext[2], ext[1], ext[0] | sticky}.
- Left mode:
  - Zero fill; ext low 3 bits are ignored.
  - out_data = in_data << shamt, truncated to WIDTH bits.
  - out_ovf = OR of all bits shifted past bit WIDTH-1.
- Saturation: shamt >= WIDTH+3 follows naturally from the stages. Logical right gives out_data = 0 and sticky = OR(in_data). Left gives out_data = 0 and ovf = OR(in_data).
- Each of the NSEG segments holds valid, data, sign, mode, remaining shamt bits, sticky and ovf.
- Segment i loads when it is empty or segment i+1 (or the output, for the last segment) accepts its content. This gives full throughput of 1 beat per cycle with no bubbles.
- in_ready = segment 0 empty, or segment 0 advancing this cycle.
- flush clears all valid bits next edge. Data contents are don't-care. If in_valid is asserted in the flush cycle, the beat is dropped and in_ready is still reported.

## Timing
- Latency: NSEG cycles from the accept edge to out_valid, with REG_EVERY=1 and WIDTH=24 giving 5.
- Output is registered. out_data, out_sign, out_grs and out_ovf hold stable while out_valid && !out_ready.
- Capacity is NSEG beats. With out_ready low, in_ready falls once all segments are full.
- Simultaneous accept and emit while full: allowed, and no loss occurs.
- Reset (rst_n low, asynchronous, at any time including mid-stream):
  - all valid bits go to 0, so out_valid = 0;
  - out_data, out_sign, out_grs and out_ovf go to 0;
  - in_ready = 1 from the first edge after release.
- in_ready depends combinationally on out_ready; no other combinational in-to-out path exists.

## Structure
- Package fp_align_pkg:
  - mode enum (SH_LSR = 2'b00, SH_ASR = 2'b01, SH_LSL = 2'b10);
  - GRS_W = 3;
  - segment struct typedef;
  - a function computing SHW from WIDTH.
- Sub-module align_shift_seg (one instance per segment):
  - combinational group of REG_EVERY conditional 2^k shifters with sticky/ovf accumulation;
  - followed by the segment register and its load/valid logic.
- The top level generates the NSEG instances and the handshake chain.

## Test plan
All scenarios use WIDTH=24, REG_EVERY=1.
- Logical right, data 0x800000, shamt 3 -> out_data 0x100000, grs 000, out_valid exactly 5 cycles after accept.
- Logical right, data 0xC00001, shamt 2 -> out_data 0x300000, grs 010. Same data, shamt 31 -> out_data 0, grs 001.
- Arithmetic right, data 0x800000, shamt 4 -> 0xF80000. Left, data 0x123456, shamt 4 -> 0x234560, ovf 1. Left, data 0x012345, shamt 4 -> ovf 0.
- Backpressure: out_ready=0, 8 back-to-back beats -> 5 accepted, then in_ready=0. Raise out_ready -> all 8 emerge in order with matching out_sign, no duplicates; random out_ready toggling is checked against a reference model.
- Mid-stream: assert rst_n low with 3 beats in flight -> out_valid 0 immediately; after release, the next beat arrives with 5-cycle latency. Repeat using flush -> same result, synchronous.
- WIDTH=53, REG_EVERY=2 -> SHW=6, latency 3. Random sweep of shamt 0..63 in all modes, compared with the reference model.

Source files
------------

// File: rtl/fp_align_pkg.sv
`default_nettype none
//============================================================================
// Package : fp_align_pkg
// Shared types and helpers for the pipelined mantissa alignment shifter.
// Rev     : 1.0
//============================================================================
package fp_align_pkg;

    typedef enum logic [1:0] {
        SH_LSR = 2'b00,
        SH_ASR = 2'b01,
        SH_LSL = 2'b10
    } sh_mode_e;

    localparam int GRS_W = 3;

    // Per-beat control carried alongside the working vector in every segment.
    typedef struct packed {
        logic     valid;
        logic     sign;
        sh_mode_e mode;
        logic     sticky;
        logic     ovf;
    } seg_ctrl_t;

    function automatic int calc_shw(input int width);
        return $clog2(width + GRS_W);
    endfunction

endpackage
`default_nettype wire

// File: rtl/align_shift_seg.sv
`default_nettype none
//============================================================================
// Module : align_shift_seg
// A group of conditional 2^k shift stages followed by one elastic register.
// Rev    : 1.0
//============================================================================
module align_shift_seg
    import fp_align_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int SHW   = 5,
    parameter int K_LO  = 0,
    parameter int K_HI  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  seg_ctrl_t              up_ctrl,
    input  logic [WIDTH+GRS_W-1:0] up_ext,
    input  logic [SHW-1:0]         up_shamt,
    output logic                   up_ready,
    output seg_ctrl_t              dn_ctrl,
    output logic [WIDTH+GRS_W-1:0] dn_ext,
    output logic [SHW-1:0]         dn_shamt,
    input  logic                   dn_ready
);

    localparam int EXTW = WIDTH + GRS_W;

    logic [EXTW-1:0] w_ext;
    logic            w_sticky;
    logic            w_ovf;

    seg_ctrl_t       ctrl_d, ctrl_q;
    logic [EXTW-1:0] ext_d, ext_q;
    logic [SHW-1:0]  shamt_d, shamt_q;

    // Right shifts collect everything falling off bit 0 into sticky;
    // left shifts collect everything falling off the MSB into ovf.
    always_comb begin
        w_ext    = up_ext;
        w_sticky = up_ctrl.sticky;
        w_ovf    = up_ctrl.ovf;
        for (int k = K_LO; k < K_HI; k++) begin
            if (up_shamt[k]) begin
                if (up_ctrl.mode == SH_LSL) begin
                    w_ovf = w_ovf | (|(w_ext & ~({EXTW{1'b1}} >> (1 << k))));
                    w_ext = w_ext << (1 << k);
                end else begin
                    w_sticky = w_sticky | (|(w_ext & ~({EXTW{1'b1}} << (1 << k))));
                    if (up_ctrl.mode == SH_ASR) begin
                        w_ext = EXTW'($signed(w_ext) >>> (1 << k));
                    end else begin
                        w_ext = w_ext >> (1 << k);
                    end
                end
            end
        end
    end

    assign up_ready = !ctrl_q.valid || dn_ready;

    always_comb begin
        ctrl_d  = ctrl_q;
        ext_d   = ext_q;
        shamt_d = shamt_q;
        if (up_ready) begin
            ctrl_d.valid = up_ctrl.valid;
            if (up_ctrl.valid) begin
                ctrl_d        = up_ctrl;
                ctrl_d.sticky = w_sticky;
                ctrl_d.ovf    = w_ovf;
                ext_d         = w_ext;
                shamt_d       = up_shamt;
            end
        end
        if (flush) begin
            ctrl_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            ext_q   <= '0;
            shamt_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            ext_q   <= ext_d;
            shamt_q <= shamt_d;
        end
    end

    assign dn_ctrl  = ctrl_q;
    assign dn_ext   = ext_q;
    assign dn_shamt = shamt_q;

endmodule
`default_nettype wire

// File: rtl/align_shift_pipe.sv
`default_nettype none
//============================================================================
// Module : align_shift_pipe
// Pipelined log2 mantissa aligner with GRS/ovf and valid/ready backpressure.
// Rev    : 1.0
//============================================================================
module align_shift_pipe
    import fp_align_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int REG_EVERY = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sign,
    input  logic [calc_shw(WIDTH)-1:0] in_shamt,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_sign,
    output logic [GRS_W-1:0]           out_grs,
    output logic                       out_ovf
);

    localparam int SHW  = calc_shw(WIDTH);
    localparam int NSEG = (SHW + REG_EVERY - 1) / REG_EVERY;
    localparam int EXTW = WIDTH + GRS_W;

    // Element 0 is the input side, element NSEG is the output register.
    seg_ctrl_t       w_ctrl  [NSEG+1];
    logic [EXTW-1:0] w_ext   [NSEG+1];
    logic [SHW-1:0]  w_shamt [NSEG+1];
    logic            w_ready [NSEG+1];
    seg_ctrl_t       w_in_ctrl;

    // The reserved mode code behaves as logical right.
    always_comb begin
        w_in_ctrl       = '0;
        w_in_ctrl.valid = in_valid;
        w_in_ctrl.sign  = in_sign;
        if (in_mode == SH_LSL) begin
            w_in_ctrl.mode = SH_LSL;
        end else if (in_mode == SH_ASR) begin
            w_in_ctrl.mode = SH_ASR;
        end else begin
            w_in_ctrl.mode = SH_LSR;
        end
    end

    assign w_ctrl[0]     = w_in_ctrl;
    assign w_ext[0]      = {in_data, {GRS_W{1'b0}}};
    assign w_shamt[0]    = in_shamt;
    assign w_ready[NSEG] = out_ready;

    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        localparam int K_LO = i * REG_EVERY;
        localparam int K_HI = (K_LO + REG_EVERY > SHW) ? SHW : (K_LO + REG_EVERY);

        align_shift_seg #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .K_LO  (K_LO),
            .K_HI  (K_HI)
        ) u_seg (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_ctrl  (w_ctrl[i]),
            .up_ext   (w_ext[i]),
            .up_shamt (w_shamt[i]),
            .up_ready (w_ready[i]),
            .dn_ctrl  (w_ctrl[i+1]),
            .dn_ext   (w_ext[i+1]),
            .dn_shamt (w_shamt[i+1]),
            .dn_ready (w_ready[i+1])
        );
    end

    assign in_ready  = w_ready[0];
    assign out_valid = w_ctrl[NSEG].valid;
    assign out_data  = w_ext[NSEG][EXTW-1:GRS_W];
    assign out_sign  = w_ctrl[NSEG].sign;

    always_comb begin
        out_grs = '0;
        out_ovf = 1'b0;
        if (w_ctrl[NSEG].mode == SH_LSL) begin
            out_ovf = w_ctrl[NSEG].ovf;
        end else begin
            out_grs = {w_ext[NSEG][2], w_ext[NSEG][1], w_ext[NSEG][0] | w_ctrl[NSEG].sticky};
        end
    end

endmodule
`default_nettype wire
